vga_capture_rx: RTL and testbench

//  Receive-side counterpart of the VGA output path: samples an incoming VGA stream
//  (h_sync, v_sync, 4-bit RGB) on a pixel-enable strobe and recovers pixel coordinates.

---
 rtl/vga_capture_rx.sv | 204 ++++++++++++++++++++
 tb/tb_vga_capture_rx.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture_rx.sv
// VGA stream receiver: samples sync/RGB on pix_en, recovers pixel coordinates,
// measures line/frame timing and only emits pixels once two matching frames have locked.
module vga_capture_rx #(
  parameter logic SYNC_POL = 1'b0,
  parameter int   H_BP     = 48,
  parameter int   H_ACTIVE = 640,
  parameter int   V_BP     = 33,
  parameter int   V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [3:0]  in_r,
  input  logic [3:0]  in_g,
  input  logic [3:0]  in_b,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [3:0]  pix_r,
  output logic [3:0]  pix_g,
  output logic [3:0]  pix_b,
  output logic        frame_start,
  output logic        locked,
  output logic [11:0] line_len,
  output logic [10:0] frame_lines,
  output logic        sync_err
);

  typedef enum logic [1:0] {SEARCH, TRAIN, VERIFY, LOCKED} state_e;

  localparam logic [11:0] H_LO = 12'(H_BP);
  localparam logic [11:0] H_HI = 12'(H_BP + H_ACTIVE);
  localparam logic [10:0] V_LO = 11'(V_BP);
  localparam logic [10:0] V_HI = 11'(V_BP + V_ACTIVE);

  state_e      state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [11:0] hcount_q, hcount_d, line_len_q, line_len_d, ref_len_q, ref_len_d;
  logic [10:0] vcount_q, vcount_d, frame_lines_q, frame_lines_d, ref_lines_q, ref_lines_d;
  logic [1:0]  hedge_q, hedge_d;
  logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
  logic        locked_q, locked_d, sync_err_q, sync_err_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [3:0]  pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;

  logic        h_act, v_act, h_trail, v_trail, line_bad, frame_bad, active;
  logic [11:0] hcount_inc;
  logic [10:0] vcount_inc;

  always_comb begin
    h_act      = (h_sync == SYNC_POL);
    v_act      = (v_sync == SYNC_POL);
    h_trail    = pix_en && hs_q && !h_act;
    v_trail    = pix_en && vs_q && !v_act;
    hcount_inc = (hcount_q == 12'hFFF) ? hcount_q : hcount_q + 12'd1;
    vcount_inc = (vcount_q == 11'h7FF) ? vcount_q : vcount_q + 11'd1;

    state_d       = state_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    ref_len_d     = ref_len_q;
    ref_lines_d   = ref_lines_q;
    hedge_d       = hedge_q;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_r_d       = pix_r_q;
    pix_g_d       = pix_g_q;
    pix_b_d       = pix_b_q;
    line_bad      = 1'b0;
    frame_bad     = 1'b0;
    active        = 1'b0;

    if (pix_en) begin
      hs_d     = h_act;
      vs_d     = v_act;
      hcount_d = h_trail ? 12'd0 : hcount_inc;
      if (v_trail)      vcount_d = 11'd0;
      else if (h_trail) vcount_d = vcount_inc;
      if (h_trail) line_len_d    = hcount_inc;
      if (v_trail) frame_lines_d = vcount_inc;

      line_bad  = h_trail && (line_len_d != ref_len_q);
      frame_bad = v_trail && (frame_lines_d != ref_lines_q);

      unique case (state_q)
        SEARCH: if (v_trail) begin
          state_d = TRAIN;
          hedge_d = 2'd0;
        end
        TRAIN: begin
          // The first hsync edge in TRAIN closes a possibly partial line, so
          // the reference is taken from the second one.
          if (line_bad && hedge_q == 2'd2) begin
            state_d    = SEARCH;
            sync_err_d = 1'b1;
          end else begin
            if (h_trail && hedge_q == 2'd1) ref_len_d = line_len_d;
            if (h_trail && hedge_q != 2'd2) hedge_d = hedge_q + 2'd1;
            if (v_trail) begin
              if (hedge_q == 2'd2) begin
                ref_lines_d = frame_lines_d;
                state_d     = VERIFY;
              end else begin
                hedge_d = 2'd0;
              end
            end
          end
        end
        VERIFY: begin
          if (line_bad || frame_bad) begin
            state_d    = SEARCH;
            sync_err_d = 1'b1;
          end else if (v_trail) begin
            state_d = LOCKED;
          end
        end
        default: if (line_bad || frame_bad) begin
          state_d    = SEARCH;
          sync_err_d = 1'b1;
        end
      endcase

      active = (hcount_d >= H_LO) && (hcount_d < H_HI) &&
               (vcount_d >= V_LO) && (vcount_d < V_HI);
      if (active && state_d == LOCKED) begin
        pix_valid_d   = 1'b1;
        pix_x_d       = 10'(hcount_d - H_LO);
        pix_y_d       = 10'(vcount_d - V_LO);
        pix_r_d       = in_r;
        pix_g_d       = in_g;
        pix_b_d       = in_b;
        frame_start_d = (pix_x_d == 10'd0) && (pix_y_d == 10'd0);
      end
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      ref_len_q     <= '0;
      ref_lines_q   <= '0;
      hedge_q       <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_r_q       <= '0;
      pix_g_q       <= '0;
      pix_b_q       <= '0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      ref_len_q     <= ref_len_d;
      ref_lines_q   <= ref_lines_d;
      hedge_q       <= hedge_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_r_q       <= pix_r_d;
      pix_g_q       <= pix_g_d;
      pix_b_q       <= pix_b_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_r       = pix_r_q;
  assign pix_g       = pix_g_q;
  assign pix_b       = pix_b_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_capture_rx.sv
// Bench for vga_capture_rx on a scaled 32x16 raster (20x10 active) with random pix_en gaps,
// a per-cycle reference model monitor, and scenario tasks for lock, loss, pause and reset.
module tb_vga_capture_rx;
  localparam logic SYNC_POL = 1'b0;
  localparam int HT = 32, HS = 4, H_BP = 4, H_ACTIVE = 20;
  localparam int VT = 16, VS = 2, V_BP = 2, V_ACTIVE = 10;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0, reset = 1'b1, pix_en = 1'b0;
  logic        h_sync = 1'b1, v_sync = 1'b1;
  logic [3:0]  in_r = '0, in_g = '0, in_b = '0;
  logic        pix_valid, frame_start, locked, sync_err;
  logic [9:0]  pix_x, pix_y;
  logic [3:0]  pix_r, pix_g, pix_b;
  logic [11:0] line_len;
  logic [10:0] frame_lines;

  vga_capture_rx #(.SYNC_POL(SYNC_POL), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE),
                   .V_BP(V_BP), .V_ACTIVE(V_ACTIVE)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .h_sync(h_sync), .v_sync(v_sync),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_start(frame_start), .locked(locked), .line_len(line_len),
    .frame_lines(frame_lines), .sync_err(sync_err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int valid_cnt = 0, fs_cnt = 0, fs_bad = 0;
  int gen_h = 0, gen_v = 0;

  // Reference model: spec rules over plain integers; stage 0..3 = search/train/verify/locked.
  int   m_h, m_v, m_line_len, m_frame_lines, m_ref_len, m_ref_lines, m_stage, m_hedges, m_x, m_y;
  bit   m_hs, m_vs, m_pv, m_fs, m_err;
  logic [3:0] m_r, m_g, m_b;

  function automatic void model_reset();
    m_h = 0; m_v = 0; m_line_len = 0; m_frame_lines = 0; m_ref_len = 0; m_ref_lines = 0;
    m_stage = 0; m_hedges = 0; m_x = 0; m_y = 0; m_hs = 0; m_vs = 0;
    m_pv = 0; m_fs = 0; m_err = 0; m_r = 0; m_g = 0; m_b = 0;
  endfunction

  function automatic void model_step(input logic hs, vs, input logic [3:0] r, g, b);
    bit ha, va, ht, vt, bad_line, bad_frame;
    int old_h, old_v, seen;
    ha = (hs == SYNC_POL); va = (vs == SYNC_POL);
    ht = m_hs && !ha;      vt = m_vs && !va;
    m_hs = ha; m_vs = va;
    old_h = m_h; old_v = m_v;
    m_h = ht ? 0 : ((old_h + 1 > 4095) ? 4095 : old_h + 1);
    if (vt) m_v = 0;
    else if (ht) m_v = (old_v + 1 > 2047) ? 2047 : old_v + 1;
    if (ht) m_line_len    = (old_h + 1 > 4095) ? 4095 : old_h + 1;
    if (vt) m_frame_lines = (old_v + 1 > 2047) ? 2047 : old_v + 1;
    bad_line  = ht && (m_line_len != m_ref_len);
    bad_frame = vt && (m_frame_lines != m_ref_lines);
    m_pv = 0; m_fs = 0; m_err = 0; seen = m_hedges;
    case (m_stage)
      0: if (vt) begin m_stage = 1; m_hedges = 0; end
      1: if (bad_line && seen == 2) m_err = 1;
         else begin
           if (ht && seen == 1) m_ref_len = m_line_len;
           if (ht && seen < 2) m_hedges = seen + 1;
           if (vt) begin
             if (seen == 2) begin m_ref_lines = m_frame_lines; m_stage = 2; end
             else m_hedges = 0;
           end
         end
      2: if (bad_line) m_err = 1;
         else if (vt) begin if (bad_frame) m_err = 1; else m_stage = 3; end
      default: if (bad_line || bad_frame) m_err = 1;
    endcase
    if (m_err) m_stage = 0;
    if (m_stage == 3 && m_h >= H_BP && m_h < H_BP + H_ACTIVE &&
        m_v >= V_BP && m_v < V_BP + V_ACTIVE) begin
      m_pv = 1; m_x = m_h - H_BP; m_y = m_v - V_BP;
      m_r = r; m_g = g; m_b = b;
      m_fs = (m_x == 0 && m_y == 0);
    end
  endfunction

  // Per-cycle monitor against the model, sampled 2 time units after each edge.
  logic mon_pe, mon_rs;
  always @(posedge clk) begin
    mon_pe = pix_en; mon_rs = reset;
    #2;
    checks++;
    if ({pix_valid, frame_start, sync_err} !== ((mon_pe && !mon_rs) ? {m_pv, m_fs, m_err} : 3'b000)) begin
      errors++;
      $display("FAIL mon_pulses t=%0t got v/fs/err=%b%b%b exp %b%b%b", $time,
               pix_valid, frame_start, sync_err, m_pv && mon_pe, m_fs && mon_pe, m_err && mon_pe);
    end
    checks++;
    if ({locked, line_len, frame_lines} !== {(m_stage == 3), 12'(m_line_len), 11'(m_frame_lines)}) begin
      errors++;
      $display("FAIL mon_status t=%0t got lock=%b len=%0d lines=%0d exp lock=%b len=%0d lines=%0d",
               $time, locked, line_len, frame_lines, m_stage == 3, m_line_len, m_frame_lines);
    end
    checks++;
    if ({pix_x, pix_y, pix_r, pix_g, pix_b} !== {10'(m_x), 10'(m_y), m_r, m_g, m_b}) begin
      errors++;
      $display("FAIL mon_data t=%0t got x=%0d y=%0d rgb=%h%h%h exp x=%0d y=%0d rgb=%h%h%h",
               $time, pix_x, pix_y, pix_r, pix_g, pix_b, m_x, m_y, m_r, m_g, m_b);
    end
    if (pix_valid) valid_cnt++;
    if (frame_start) begin
      fs_cnt++;
      if (pix_x != 0 || pix_y != 0) fs_bad++;
    end
  end

  function automatic logic hs_pin(input int h);
    return (h >= HT - HS) ? SYNC_POL : ~SYNC_POL;
  endfunction
  function automatic logic vs_pin(input int v);
    return (v >= VT - VS) ? SYNC_POL : ~SYNC_POL;
  endfunction
  function automatic void advance();
    gen_h++;
    if (gen_h == HT) begin gen_h = 0; gen_v = (gen_v + 1) % VT; end
  endfunction

  // Caller is at a negedge; returns at the next negedge with the sample's outputs registered.
  task automatic drive_sample(input logic hs, vs, input logic [3:0] r, g, b);
    pix_en = 1'b1; h_sync = hs; v_sync = vs; in_r = r; in_g = g; in_b = b;
    model_step(hs, vs, r, g, b);
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic next_pixel();
    drive_sample(hs_pin(gen_h), vs_pin(gen_v), 4'($urandom), 4'($urandom), 4'($urandom));
    advance();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic stream_n(input int n);
    repeat (n) next_pixel();
  endtask

  task automatic stream_to(input int tv, input int th);
    while (!(gen_v == tv && gen_h == th)) next_pixel();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start, locked, line_len,
         frame_lines, sync_err} !== 59'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b x=%0d y=%0d lock=%b len=%0d lines=%0d err=%b, need all 0",
               pix_valid, pix_x, pix_y, locked, line_len, frame_lines, sync_err);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_lock();
    for (int f = 0; f < 3; f++) begin
      stream_n(FRAME);
      checks++;
      if (locked !== 1'b0) begin
        errors++; $display("FAIL lock_early frame=%0d got locked=%b need 0", f, locked);
      end
    end
    next_pixel();
    checks++;
    if ({locked, line_len, frame_lines, sync_err} !== {1'b1, 12'(HT), 11'(VT), 1'b0}) begin
      errors++;
      $display("FAIL lock_third_vsync got lock=%b len=%0d lines=%0d need 1/%0d/%0d",
               locked, line_len, frame_lines, HT, VT);
    end
  endtask

  task automatic test_pixel();
    stream_to(V_BP + 7, H_BP + 5);
    drive_sample(hs_pin(gen_h), vs_pin(gen_v), 4'hA, 4'h5, 4'h3);
    advance();
    checks++;
    if ({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b} !== {1'b1, 10'd5, 10'd7, 4'hA, 4'h5, 4'h3}) begin
      errors++;
      $display("FAIL pixel_5_7 got v=%b x=%0d y=%0d rgb=%h%h%h need 1 5 7 A53",
               pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b);
    end
    @(negedge clk);
    checks++;
    if ({pix_valid, pix_x, pix_y} !== {1'b0, 10'd5, 10'd7}) begin
      errors++;
      $display("FAIL pixel_hold got v=%b x=%0d y=%0d need 0 5 7", pix_valid, pix_x, pix_y);
    end
  endtask

  task automatic test_frame_count();
    stream_to(0, 0);
    valid_cnt = 0; fs_cnt = 0; fs_bad = 0;
    stream_n(FRAME);
    checks++;
    if (valid_cnt !== H_ACTIVE * V_ACTIVE || fs_cnt !== 1 || fs_bad !== 0) begin
      errors++;
      $display("FAIL frame_count got valid=%0d fs=%0d fs_off=%0d need %0d 1 0",
               valid_cnt, fs_cnt, fs_bad, H_ACTIVE * V_ACTIVE);
    end
  endtask

  task automatic test_short_line();
    stream_to(4, HT - 1);
    advance();
    drive_sample(hs_pin(gen_h), vs_pin(gen_v), 4'h1, 4'h2, 4'h3);
    advance();
    checks++;
    if ({sync_err, locked, line_len} !== {1'b1, 1'b0, 12'(HT - 1)}) begin
      errors++;
      $display("FAIL short_line got err=%b lock=%b len=%0d need 1 0 %0d", sync_err, locked, line_len, HT - 1);
    end
    @(negedge clk);
    checks++;
    if (sync_err !== 1'b0) begin
      errors++; $display("FAIL short_err_pulse got err=%b need 0", sync_err);
    end
    valid_cnt = 0;
    stream_to(0, 0);
    stream_n(2 * FRAME);
    checks++;
    if (locked !== 1'b0 || valid_cnt !== 0) begin
      errors++; $display("FAIL short_relock_early got lock=%b valid=%0d need 0 0", locked, valid_cnt);
    end
    next_pixel();
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL short_relock got lock=%b need 1", locked);
    end
  endtask

  task automatic test_pause();
    logic [55:0] rec;
    int vc;
    stream_to(8, 10);
    rec = {locked, line_len, frame_lines, pix_x, pix_y, pix_r, pix_g, pix_b};
    vc = valid_cnt;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      h_sync = 1'($urandom); v_sync = 1'($urandom); in_r = 4'($urandom);
    end
    checks++;
    if ({locked, line_len, frame_lines, pix_x, pix_y, pix_r, pix_g, pix_b} !== rec || valid_cnt !== vc) begin
      errors++;
      $display("FAIL pause_frozen got %h valid=%0d need %h valid=%0d",
               {locked, line_len, frame_lines, pix_x, pix_y, pix_r, pix_g, pix_b}, valid_cnt, rec, vc);
    end
    stream_to(0, 0);
    valid_cnt = 0;
    stream_n(FRAME);
    checks++;
    if (valid_cnt !== H_ACTIVE * V_ACTIVE || locked !== 1'b1) begin
      errors++; $display("FAIL pause_resume got valid=%0d lock=%b need %0d 1", valid_cnt, locked, H_ACTIVE * V_ACTIVE);
    end
  endtask

  task automatic test_reset_mid();
    stream_to(7, 12);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got lock=%b need 1", locked);
    end
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if ({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start, locked, line_len,
         frame_lines, sync_err} !== 59'd0) begin
      errors++;
      $display("FAIL rstmid_zero got v=%b x=%0d y=%0d lock=%b len=%0d lines=%0d need all 0",
               pix_valid, pix_x, pix_y, locked, line_len, frame_lines);
    end
    reset = 1'b0;
    stream_to(0, 0);
    stream_n(2 * FRAME);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL rstmid_early got lock=%b need 0", locked);
    end
    next_pixel();
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL rstmid_relock got lock=%b need 1", locked);
    end
  endtask

  task automatic test_random_sync();
    for (int i = 0; i < 400; i++) begin
      drive_sample(($urandom_range(0, 3) == 0) ? SYNC_POL : ~SYNC_POL,
                   ($urandom_range(0, 7) == 0) ? SYNC_POL : ~SYNC_POL,
                   4'($urandom), 4'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    checks++;
    if (locked !== (m_stage == 3) || line_len !== 12'(m_line_len)) begin
      errors++;
      $display("FAIL random_sync got lock=%b len=%0d need %b %0d", locked, line_len, m_stage == 3, m_line_len);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_pixel();
    test_frame_count();
    test_short_line();
    test_pause();
    test_reset_mid();
    test_random_sync();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
